// File: rtl/core_pkg.sv
// Shared core definitions: sequencer state/trap encodings and the base opcode set
// recognised by the decoder.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_TRAP      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    TRAP_NONE        = 2'd0,
    TRAP_ILLEGAL     = 2'd1,
    TRAP_MEM_TIMEOUT = 2'd2
  } trap_cause_t;

  typedef struct packed {
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic ir_en;
    logic pc_en;
    logic rf_we;
    logic halted;
  } strobes_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Decoder helper: true for the nine base opcodes the core executes.
  function automatic logic is_base_opcode(input logic [6:0] opc);
    logic hit_s;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: hit_s = 1'b1;
      default:                                 hit_s = 1'b0;
    endcase
    return hit_s;
  endfunction

endpackage

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps each instruction through fetch, decode,
// execute, optional memory access and writeback, with halt and sticky trap states.
module multicycle_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_ready,
  input  logic                 dec_valid_op,
  input  logic                 dec_mem_read,
  input  logic                 dec_mem_write,
  input  logic                 dec_reg_write,
  input  logic                 halt_req,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_en,
  output logic                 pc_en,
  output logic                 rf_we,
  output logic [2:0]           state,
  output logic                 halted,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t                state_r;
  state_t                state_s;
  trap_cause_t           cause_r;
  trap_cause_t           cause_s;
  logic [WAIT_W-1:0]     wait_r;
  logic [WAIT_W-1:0]     wait_s;
  logic [INSTRET_W-1:0]  instret_r;
  logic                  mem_phase_s;
  logic                  timeout_s;
  strobes_t              strb_s;

  // The wait counter only runs while an access is stalled; any completed access or
  // non-memory state leaves it at zero, so every FETCH/MEM entry starts from zero.
  assign mem_phase_s = (state_r == ST_FETCH) || (state_r == ST_MEM);
  assign timeout_s   = mem_phase_s && !mem_ready && (wait_r == WAIT_LAST);

  // State, trap cause and wait counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
      cause_r <= TRAP_NONE;
      wait_r  <= '0;
    end else begin
      state_r <= state_s;
      cause_r <= cause_s;
      wait_r  <= wait_s;
    end
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_r <= '0;
    end else if (state_r == ST_WRITEBACK) begin
      instret_r <= instret_r + INSTRET_W'(1);
    end else begin
      instret_r <= instret_r;
    end
  end

  // Next-state, trap cause and wait counter logic.
  always_comb begin
    state_s = state_r;
    cause_s = cause_r;
    if (mem_phase_s && !mem_ready) begin
      wait_s = wait_r + WAIT_W'(1);
    end else begin
      wait_s = '0;
    end
    case (state_r)
      ST_FETCH, ST_MEM: begin
        // A late mem_ready in the final allowed cycle still completes the access.
        if (mem_ready) begin
          state_s = (state_r == ST_FETCH) ? ST_DECODE : ST_WRITEBACK;
        end else if (timeout_s) begin
          state_s = ST_TRAP;
          cause_s = TRAP_MEM_TIMEOUT;
        end else begin
          state_s = state_r;
        end
      end
      ST_DECODE: begin
        if (dec_valid_op) begin
          state_s = ST_EXECUTE;
        end else begin
          state_s = ST_TRAP;
          cause_s = TRAP_ILLEGAL;
        end
      end
      ST_EXECUTE: begin
        if (dec_mem_read || dec_mem_write) begin
          state_s = ST_MEM;
        end else begin
          state_s = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK, ST_HALT: begin
        if (halt_req) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_TRAP: begin
        state_s = ST_TRAP;
      end
      default: begin
        state_s = ST_TRAP;
        cause_s = cause_r;
      end
    endcase
  end

  // Output decode from the current state; everything is held low during reset.
  always_comb begin
    strb_s = '0;
    if (!rst_n) begin
      strb_s = '0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          strb_s.mem_req = 1'b1;
          strb_s.ir_en   = mem_ready;
        end
        ST_MEM: begin
          strb_s.mem_req      = 1'b1;
          strb_s.mem_we       = dec_mem_write;
          strb_s.mem_addr_sel = 1'b1;
        end
        ST_WRITEBACK: begin
          strb_s.pc_en = 1'b1;
          strb_s.rf_we = dec_reg_write;
        end
        ST_HALT, ST_TRAP: begin
          strb_s.halted = 1'b1;
        end
        ST_DECODE, ST_EXECUTE: begin
          strb_s = '0;
        end
        default: begin
          strb_s.halted = 1'b1;
        end
      endcase
    end
  end

  assign mem_req      = strb_s.mem_req;
  assign mem_we       = strb_s.mem_we;
  assign mem_addr_sel = strb_s.mem_addr_sel;
  assign ir_en        = strb_s.ir_en;
  assign pc_en        = strb_s.pc_en;
  assign rf_we        = strb_s.rf_we;
  assign halted       = strb_s.halted;
  assign state        = state_r;
  assign trap_cause   = cause_r;
  assign instret      = instret_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: the stimulus side plans each instruction from its latency rules
// and queues the expected outputs per cycle; a monitor pops and compares them.
module tb_multicycle_sequencer;
  import core_pkg::*;

  localparam int TIMEOUT   = 4;
  localparam int INSTRET_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_ready = 1'b0;
  logic dec_valid_op = 1'b0;
  logic dec_mem_read = 1'b0;
  logic dec_mem_write = 1'b0;
  logic dec_reg_write = 1'b0;
  logic halt_req = 1'b0;
  logic mem_req, mem_we, mem_addr_sel, ir_en, pc_en, rf_we, halted;
  logic [2:0] state;
  logic [1:0] trap_cause;
  logic [INSTRET_W-1:0] instret;

  always #5 clk = ~clk;

  multicycle_sequencer #(.TIMEOUT(TIMEOUT), .INSTRET_W(INSTRET_W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .dec_valid_op(dec_valid_op),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .halt_req(halt_req), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_en(ir_en), .pc_en(pc_en),
    .rf_we(rf_we), .state(state), .halted(halted), .trap_cause(trap_cause),
    .instret(instret)
  );

  typedef struct {
    logic [2:0]           st;
    logic [6:0]           strb;   // mem_req, mem_we, mem_addr_sel, ir_en, pc_en, rf_we, halted
    logic [1:0]           cause;
    logic [INSTRET_W-1:0] iret;
    bit                   chk_sel;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_instret = 0;
  int   m_cause = 0;

  exp_t       mon_e;
  logic [6:0] mon_strb;

  task automatic expect_out(input state_t st, input logic mreq, input logic mwe,
                            input logic asel, input logic ir, input logic pc,
                            input logic rf, input logic hlt, input bit chk_sel);
    exp_t e;
    e.st      = st;
    e.strb    = {mreq, mwe, asel, ir, pc, rf, hlt};
    e.cause   = m_cause[1:0];
    e.iret    = m_instret[INSTRET_W-1:0];
    e.chk_sel = chk_sel;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one comparison per cycle in which an expectation is pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e    = exp_q.pop_front();
      mon_strb = {mem_req, mem_we, mem_addr_sel, ir_en, pc_en, rf_we, halted};
      if (!mon_e.chk_sel) mon_strb[4] = mon_e.strb[4];
      n_cmp++;
      if ({state, mon_strb, trap_cause, instret} !== {mon_e.st, mon_e.strb, mon_e.cause, mon_e.iret}) begin
        n_err++;
        $display("FAIL cycle_outputs t=%0t actual st=%0d strb=%b cause=%0d iret=%0d required st=%0d strb=%b cause=%0d iret=%0d",
                 $time, state, mon_strb, trap_cause, instret, mon_e.st, mon_e.strb, mon_e.cause, mon_e.iret);
      end
    end
  end

  task automatic reset_seq(input state_t cur);
    rst_n = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    halt_req = 1'($urandom_range(0, 1));
    expect_out(cur, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    m_instret = 0;
    m_cause = 0;
    expect_out(ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    rst_n = 1'b1;
  endtask

  task automatic trap_hold(input int n);
    for (int k = 0; k < n; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      expect_out(ST_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
    end
    reset_seq(ST_TRAP);
  endtask

  // One memory access: ready stays low for 'waits' cycles; TIMEOUT low cycles trap.
  task automatic access(input state_t st, input int waits, input logic we, output bit trapped);
    logic rdy;
    trapped = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      rdy = (i >= waits);
      mem_ready = rdy;
      halt_req = 1'($urandom_range(0, 1));
      expect_out(st, 1'b1, (st == ST_MEM) ? we : 1'b0, st == ST_MEM,
                 (st == ST_FETCH) ? rdy : 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      if (rdy) return;
    end
    trapped = 1'b1;
    m_cause = 2;
  endtask

  task automatic run_instr(input logic valid, input logic rd, input logic wr, input logic rw,
                           input int fw, input int mw, input int h);
    bit trapped;
    dec_valid_op = valid;
    dec_mem_read = rd;
    dec_mem_write = wr;
    dec_reg_write = rw;
    access(ST_FETCH, fw, wr, trapped);
    if (trapped) begin
      trap_hold(3);
      return;
    end
    mem_ready = 1'($urandom_range(0, 1));
    halt_req = 1'($urandom_range(0, 1));
    expect_out(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    if (!valid) begin
      m_cause = 1;
      trap_hold(20);
      return;
    end
    mem_ready = 1'($urandom_range(0, 1));
    halt_req = 1'($urandom_range(0, 1));
    expect_out(ST_EXECUTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    if (rd || wr) begin
      access(ST_MEM, mw, wr, trapped);
      if (trapped) begin
        trap_hold(3);
        return;
      end
    end
    halt_req = (h > 0);
    mem_ready = 1'($urandom_range(0, 1));
    expect_out(ST_WRITEBACK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rw, 1'b0, 1'b1);
    step();
    m_instret = (m_instret + 1) % (1 << INSTRET_W);
    for (int j = 0; j < h; j++) begin
      halt_req = (j < h - 1);
      mem_ready = 1'($urandom_range(0, 1));
      expect_out(ST_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
    end
    halt_req = 1'b0;
  endtask

  task automatic abort_load();
    bit trapped;
    dec_valid_op = 1'b1;
    dec_mem_read = 1'b1;
    dec_mem_write = 1'b0;
    dec_reg_write = 1'b1;
    access(ST_FETCH, 0, 1'b0, trapped);
    expect_out(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    expect_out(ST_EXECUTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b0;
      expect_out(ST_MEM, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    reset_seq(ST_MEM);
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 1))
                                       : int'($urandom_range(0, 2));
  endfunction

  initial begin
    int kind;
    step();
    reset_seq(ST_FETCH);
    for (int i = 0; i < 17; i++) run_instr(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    run_instr(1'b1, 1'b1, 1'b0, 1'b1, 0, 2, 0);
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 2);
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, TIMEOUT - 1, 0, 1);
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, TIMEOUT, 0, 0);
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 0, TIMEOUT - 1, 0);
    run_instr(1'b1, 1'b1, 1'b0, 1'b1, 0, TIMEOUT, 0);
    abort_load();
    run_instr(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 2));
      run_instr(1'($urandom_range(0, 11) != 0), 1'(kind == 1), 1'(kind == 2),
                1'($urandom_range(0, 1)), rand_wait(), rand_wait(),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain actual %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
